// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output and error pulses.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err port.
module uart_rx #(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD_RATE = 9600,
  parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_e;
`endif

  state_e        state_q, state_d;
  logic          meta_q, rxs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          tick;
  logic          bad;
`ifdef UART_RX_PARITY_EN
  logic          pe_q, pe_d;
  logic          pbad_q, pbad_d;
  assign bad = pbad_q;
`else
  assign bad = 1'b0;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d      = 1'b0;
    pbad_d    = pbad_q;
`endif
    if (valid_q && ready) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          cnt_d   = HALF_LD;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = FULL_LD;
          idx_d   = 3'd0;
          state_d = DATA;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = FULL_LD;
          state_d = STOP;
          if (rxs_q != ^shift_q) begin
            pe_d   = 1'b1;
            pbad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxs_q) begin
          fe_d    = 1'b1;
          state_d = BREAK;
        end else begin
          state_d = IDLE;
          if (!bad) begin
            // A same-cycle accept frees the register for the new byte
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q    <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      meta_q  <= rx;
      rxs_q   <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      pe_q    <= pe_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule
